// File: rtl/rstring_tap_seq.sv
// POR resistor-string tap mux controller: string enable, one-hot tap select with
// break-before-make, settling timers, valid flag and an automatic 8-tap trim sweep.
module rstring_tap_seq #(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned BBM_CYC    = 2,
    parameter int unsigned DWELL_CYC  = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_req,
    input  logic [2:0] otrip,
    input  logic       otrip_wr,
    input  logic       sweep_start,
    output logic       ena,
    output logic [7:0] otrip_decoded,
    output logic       vin_valid,
    output logic       busy,
    output logic [2:0] sweep_idx,
    output logic       sweep_done
);

    typedef enum logic [2:0] {
        S_OFF,
        S_ENA_SETTLE,
        S_BBM,
        S_TAP_SETTLE,
        S_READY,
        S_DWELL
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] BBM_LD    = CNT_W'(BBM_CYC - 1);
    localparam logic [CNT_W-1:0] DWELL_LD  = CNT_W'(DWELL_CYC - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       cur_code, cur_code_n;
    logic [2:0]       pend_code, pend_code_n;
    logic             sweeping, sweeping_n;
    logic             restoring, restoring_n;
    logic [2:0]       sweep_idx_n;
    logic             sweep_done_n;
    logic             ena_n;
    logic [7:0]       decoded_n;
    logic             vin_valid_n;
    logic             busy_n;

    function automatic logic [7:0] onehot(input logic [2:0] code);
        logic [7:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_OFF;
            cnt           <= '0;
            cur_code      <= '0;
            pend_code     <= '0;
            sweeping      <= 1'b0;
            restoring     <= 1'b0;
            ena           <= 1'b0;
            otrip_decoded <= '0;
            vin_valid     <= 1'b0;
            busy          <= 1'b0;
            sweep_idx     <= '0;
            sweep_done    <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            cur_code      <= cur_code_n;
            pend_code     <= pend_code_n;
            sweeping      <= sweeping_n;
            restoring     <= restoring_n;
            ena           <= ena_n;
            otrip_decoded <= decoded_n;
            vin_valid     <= vin_valid_n;
            busy          <= busy_n;
            sweep_idx     <= sweep_idx_n;
            sweep_done    <= sweep_done_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        cur_code_n   = cur_code;
        pend_code_n  = pend_code;
        sweeping_n   = sweeping;
        restoring_n  = restoring;
        sweep_idx_n  = sweep_idx;
        sweep_done_n = 1'b0;

        if (otrip_wr) begin
            pend_code_n = otrip;
            if (state == S_OFF) begin
                cur_code_n = otrip;
            end
        end

        if (!ena_req) begin
            state_n     = S_OFF;
            cnt_n       = '0;
            cur_code_n  = pend_code_n;
            sweeping_n  = 1'b0;
            restoring_n = 1'b0;
            sweep_idx_n = '0;
        end else begin
            unique case (state)
                S_OFF: begin
                    state_n = S_ENA_SETTLE;
                    cnt_n   = SETTLE_LD;
                end
                S_ENA_SETTLE: begin
                    if (cnt == '0) begin
                        state_n = S_TAP_SETTLE;
                        cnt_n   = SETTLE_LD;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_BBM: begin
                    if (cnt == '0) begin
                        state_n = S_TAP_SETTLE;
                        cnt_n   = SETTLE_LD;
                        // Outside a sweep the newest pending code is connected, so a
                        // write landing during the open interval never flashes the stale tap.
                        if (!sweeping) begin
                            cur_code_n = pend_code_n;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_TAP_SETTLE: begin
                    if (cnt == '0) begin
                        if (sweeping) begin
                            state_n = S_DWELL;
                            cnt_n   = DWELL_LD;
                        end else begin
                            state_n = S_READY;
                            cnt_n   = '0;
                            if (restoring) begin
                                restoring_n  = 1'b0;
                                sweep_done_n = 1'b1;
                            end
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_READY: begin
                    if (sweep_start) begin
                        sweeping_n  = 1'b1;
                        cur_code_n  = '0;
                        sweep_idx_n = '0;
                        state_n     = S_BBM;
                        cnt_n       = BBM_LD;
                    end else if (pend_code != cur_code) begin
                        cur_code_n = pend_code;
                        state_n    = S_BBM;
                        cnt_n      = BBM_LD;
                    end
                end
                S_DWELL: begin
                    if (cnt == '0) begin
                        state_n = S_BBM;
                        cnt_n   = BBM_LD;
                        if (sweep_idx != 3'd7) begin
                            sweep_idx_n = sweep_idx + 3'd1;
                            cur_code_n  = cur_code + 3'd1;
                        end else begin
                            sweeping_n  = 1'b0;
                            restoring_n = 1'b1;
                            cur_code_n  = pend_code_n;
                        end
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: begin
                    state_n = S_OFF;
                    cnt_n   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so every output is a flop.
        ena_n       = (state_n != S_OFF);
        vin_valid_n = (state_n == S_READY) || (state_n == S_DWELL);
        busy_n      = (state_n == S_ENA_SETTLE) || (state_n == S_BBM) ||
                      (state_n == S_TAP_SETTLE) || (state_n == S_DWELL);
        decoded_n   = '0;
        if ((state_n == S_TAP_SETTLE) || (state_n == S_READY) || (state_n == S_DWELL)) begin
            decoded_n = onehot(cur_code_n);
        end
    end

endmodule
